// File: rtl/sync_fifo_v3.sv
// Synchronous FIFO with full/empty flags, fill level and optional fall-through bypass.
// Define FIFO_ASSERT_EN to compile in simulation-only overflow/underflow assertions.
module sync_fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    if (DEPTH == 0) begin : g_passthru
        logic unused_ok;
        assign unused_ok = ^{clk_i, rst_i, flush_i, testmode_i};

        assign data_o  = data_i;
        assign empty_o = !push_i;
        assign full_o  = !pop_i;
        assign usage_o = '0;
    end else begin : g_fifo
        localparam int unsigned CNT_W = ADDR_DEPTH + 1;
        localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
        localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);

        logic unused_ok;
        assign unused_ok = testmode_i;

        logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
        logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
        logic [CNT_W-1:0]      cnt_q, cnt_d;
        dtype                  mem_q [DEPTH];

        logic is_full, is_empty, bypass, push_ok, pop_ok;

        assign is_full  = (cnt_q == FULL_CNT);
        assign is_empty = (cnt_q == '0);
        assign bypass   = FALL_THROUGH && is_empty && push_i;
        // A bypassed element that is popped in the same cycle never touches storage.
        assign push_ok  = push_i && !is_full && !(bypass && pop_i);
        assign pop_ok   = pop_i && !is_empty;

        always_comb begin
            // NOTE: every always_comb output gets a default first so no path can infer a latch.
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            cnt_d    = cnt_q;
            if (flush_i) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                cnt_d    = '0;
            end else begin
                if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
                if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
                if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
                else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
                // NOTE: memory is cleared on reset so data_o reads 0 afterwards; this costs a reset net per bit.
                for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                cnt_q    <= cnt_d;
                if (push_ok) mem_q[wr_ptr_q] <= data_i;
            end
        end

        assign full_o  = is_full;
        assign empty_o = is_empty && !(FALL_THROUGH && push_i);
        assign usage_o = cnt_q[ADDR_DEPTH-1:0];
        assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
    end

`ifdef FIFO_ASSERT_EN
    a_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o))
        else $error("sync_fifo_v3: push while full");
    a_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o))
        else $error("sync_fifo_v3: pop while empty");
`endif

endmodule

// File: tb/tb_sync_fifo_v3.sv
// Directed bench for sync_fifo_v3: DEPTH 8 (plain and fall-through), DEPTH 0 and DEPTH 5.
module tb_sync_fifo_v3;

    logic clk = 1'b0;
    logic rst;
    logic testmode = 1'b0;
    always #5 clk = ~clk;

    // a: DEPTH 8, b: DEPTH 8 fall-through, c: DEPTH 0, d: DEPTH 5
    logic       push_a, pop_a, flush_a, full_a, empty_a;
    logic [7:0] din_a, dout_a;
    logic [2:0] use_a;
    logic       push_b, pop_b, flush_b, full_b, empty_b;
    logic [7:0] din_b, dout_b;
    logic [2:0] use_b;
    logic       push_c, pop_c, flush_c, full_c, empty_c;
    logic [7:0] din_c, dout_c;
    logic [0:0] use_c;
    logic       push_d, pop_d, flush_d, full_d, empty_d;
    logic [7:0] din_d, dout_d;
    logic [2:0] use_d;

    sync_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(8)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .testmode_i(testmode),
        .full_o(full_a), .empty_o(empty_a), .usage_o(use_a),
        .data_i(din_a), .push_i(push_a), .data_o(dout_a), .pop_i(pop_a));
    sync_fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(8)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .testmode_i(testmode),
        .full_o(full_b), .empty_o(empty_b), .usage_o(use_b),
        .data_i(din_b), .push_i(push_b), .data_o(dout_b), .pop_i(pop_b));
    sync_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0)) u_c (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_c), .testmode_i(testmode),
        .full_o(full_c), .empty_o(empty_c), .usage_o(use_c),
        .data_i(din_c), .push_i(push_c), .data_o(dout_c), .pop_i(pop_c));
    sync_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(5)) u_d (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_d), .testmode_i(testmode),
        .full_o(full_d), .empty_o(empty_d), .usage_o(use_d),
        .data_i(din_d), .push_i(push_d), .data_o(dout_d), .pop_i(pop_d));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] v;

    initial begin
        rst = 1'b1;
        {push_a, pop_a, flush_a, din_a} = '0;
        {push_b, pop_b, flush_b, din_b} = '0;
        {push_c, pop_c, flush_c, din_c} = '0;
        {push_d, pop_d, flush_d, din_d} = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_empty", 32'(empty_a), 1);
        check("rst_full",  32'(full_a),  0);
        check("rst_usage", 32'(use_a),   0);
        check("rst_data",  32'(dout_a),  0);

        // Fill 0xA0..0xA7; usage wraps to 0 when full.
        for (int i = 0; i < 8; i++) begin
            push_a = 1'b1; din_a = 8'hA0 + 8'(i);
            tick();
            check("fill_usage", 32'(use_a), 32'((i + 1) % 8));
            check("fill_full",  32'(full_a), (i == 7) ? 1 : 0);
        end
        push_a = 1'b0;
        check("fill_head", 32'(dout_a), 32'h A0);
        check("fill_nempty", 32'(empty_a), 0);

        // Push while full is dropped.
        push_a = 1'b1; din_a = 8'hFF;
        tick();
        push_a = 1'b0;
        check("ovf_full", 32'(full_a), 1);
        check("ovf_head", 32'(dout_a), 32'h A0);

        for (int i = 0; i < 8; i++) begin
            check("drain_data", 32'(dout_a), 32'(8'hA0 + 8'(i)));
            pop_a = 1'b1;
            tick();
        end
        pop_a = 1'b0;
        check("drain_empty", 32'(empty_a), 1);
        check("drain_usage", 32'(use_a), 0);

        // Underflow pop leaves state alone.
        pop_a = 1'b1;
        tick();
        pop_a = 1'b0;
        check("udf_empty", 32'(empty_a), 1);
        check("udf_usage", 32'(use_a), 0);

        // Simultaneous push/pop at count 3 across 20 cycles.
        q.delete();
        for (int i = 0; i < 3; i++) begin
            push_a = 1'b1; din_a = 8'hB0 + 8'(i); q.push_back(din_a);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            check("pp_data",  32'(dout_a), 32'(q[0]));
            check("pp_usage", 32'(use_a), 3);
            push_a = 1'b1; pop_a = 1'b1; din_a = 8'h10 + 8'(i);
            q.push_back(din_a);
            v = q.pop_front();
            tick();
        end
        push_a = 1'b0; pop_a = 1'b0;
        check("pp_usage_end", 32'(use_a), 3);
        while (q.size() > 0) begin
            v = q.pop_front();
            check("pp_drain", 32'(dout_a), 32'(v));
            pop_a = 1'b1;
            tick();
        end
        pop_a = 1'b0;
        check("pp_empty", 32'(empty_a), 1);

        // Flush beats a simultaneous push.
        for (int i = 0; i < 5; i++) begin
            push_a = 1'b1; din_a = 8'hC0 + 8'(i);
            tick();
        end
        check("fl_usage5", 32'(use_a), 5);
        push_a = 1'b1; flush_a = 1'b1; din_a = 8'hEE;
        tick();
        push_a = 1'b0; flush_a = 1'b0;
        check("fl_empty", 32'(empty_a), 1);
        check("fl_usage", 32'(use_a), 0);
        push_a = 1'b1; din_a = 8'h11;
        tick();
        push_a = 1'b0;
        check("fl_head",   32'(dout_a), 32'h11);
        check("fl_usage1", 32'(use_a), 1);

        // Reset mid-operation discards queued data.
        push_a = 1'b1; din_a = 8'h22;
        tick();
        push_a = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mrst_empty", 32'(empty_a), 1);
        check("mrst_usage", 32'(use_a), 0);
        check("mrst_data",  32'(dout_a), 0);

        // Fall-through: pass-through with pop, then bypass without pop.
        push_b = 1'b1; pop_b = 1'b1; din_b = 8'h55;
        #1;
        check("ft_data",  32'(dout_b), 32'h55);
        check("ft_empty", 32'(empty_b), 0);
        tick();
        push_b = 1'b0; pop_b = 1'b0;
        #1;
        check("ft_after_empty", 32'(empty_b), 1);
        check("ft_after_usage", 32'(use_b), 0);
        push_b = 1'b1; din_b = 8'h66;
        #1;
        check("ft_push_data", 32'(dout_b), 32'h66);
        tick();
        push_b = 1'b0;
        #1;
        check("ft_stored_usage", 32'(use_b), 1);
        check("ft_stored_data",  32'(dout_b), 32'h66);
        check("ft_stored_empty", 32'(empty_b), 0);

        // DEPTH 0 combinational behaviour.
        push_c = 1'b1; pop_c = 1'b0; din_c = 8'h3C;
        #1;
        check("d0_data",  32'(dout_c), 32'h3C);
        check("d0_empty", 32'(empty_c), 0);
        check("d0_full",  32'(full_c), 1);
        push_c = 1'b0; pop_c = 1'b1; din_c = 8'hC3;
        #1;
        check("d0_data2",  32'(dout_c), 32'hC3);
        check("d0_empty2", 32'(empty_c), 1);
        check("d0_full2",  32'(full_c), 0);
        check("d0_usage",  32'(use_c), 0);

        // DEPTH 5: fill, push+pop at full drops the push, then wrap over 12 cycles.
        q.delete();
        for (int i = 0; i < 5; i++) begin
            push_d = 1'b1; din_d = 8'hD0 + 8'(i); q.push_back(din_d);
            tick();
            check("d5_full", 32'(full_d), (i == 4) ? 1 : 0);
        end
        check("d5_usage5", 32'(use_d), 5);
        push_d = 1'b1; pop_d = 1'b1; din_d = 8'hEE;
        v = q.pop_front();
        tick();
        check("d5_fullpp_usage", 32'(use_d), 4);
        check("d5_fullpp_head",  32'(dout_d), 32'(q[0]));
        for (int i = 0; i < 12; i++) begin
            check("d5_pp_data", 32'(dout_d), 32'(q[0]));
            push_d = 1'b1; pop_d = 1'b1; din_d = 8'h40 + 8'(i);
            q.push_back(din_d);
            v = q.pop_front();
            tick();
        end
        push_d = 1'b0; pop_d = 1'b0;
        check("d5_pp_usage", 32'(use_d), 4);
        while (q.size() > 0) begin
            v = q.pop_front();
            check("d5_drain", 32'(dout_d), 32'(v));
            pop_d = 1'b1;
            tick();
        end
        pop_d = 1'b0;
        check("d5_empty", 32'(empty_d), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
